memory_port_arbiter: RTL and testbench

//  Shares one 32-bit memory port between instruction fetch (IF/ID stage) and data access (MEM stage).
//  One transaction is outstanding at a time. Data accesses have priority; a starvation counter guarantees fetch progress.
//  A fetch flush drops the response of an in-flight fetch. Sits between the core pipeline and the memory/bus slave.

---
 rtl/memory_port_arbiter_if.sv | 45 ++++
 rtl/memory_port_arbiter.sv | 107 ++++++++++
 tb/tb_memory_port_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_if.sv
// Bundle of the pipeline-side and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; the master modport is the core + memory view.
// Pure wiring, no state.
interface memory_port_arbiter_if;
  // instruction fetch side
  logic        instruction_request_i;
  logic        flush_bus_i;
  logic [31:0] instruction_addr_i;
  logic        instruction_response_o;
  logic [31:0] instruction_data_o;
  // data access side
  logic        data_read_request_i;
  logic        data_write_request_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_write_data_i;
  logic [3:0]  data_strobe_i;
  logic        data_response_o;
  logic [31:0] data_read_data_o;
  // memory side
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_write_data_o;
  logic [3:0]  mem_strobe_o;
  logic        mem_ack_i;
  logic [31:0] mem_read_data_i;

  modport slave (
    input  instruction_request_i, flush_bus_i, instruction_addr_i,
    output instruction_response_o, instruction_data_o,
    input  data_read_request_i, data_write_request_i, data_addr_i, data_write_data_i, data_strobe_i,
    output data_response_o, data_read_data_o,
    output mem_read_o, mem_write_o, mem_addr_o, mem_write_data_o, mem_strobe_o,
    input  mem_ack_i, mem_read_data_i
  );

  modport master (
    output instruction_request_i, flush_bus_i, instruction_addr_i,
    input  instruction_response_o, instruction_data_o,
    output data_read_request_i, data_write_request_i, data_addr_i, data_write_data_i, data_strobe_i,
    input  data_response_o, data_read_data_o,
    input  mem_read_o, mem_write_o, mem_addr_o, mem_write_data_o, mem_strobe_o,
    output mem_ack_i, mem_read_data_i
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and data access, one transaction at a time.
// Latency: command rises the cycle after grant; response pulses the cycle after mem_ack_i.
// Backpressure: requests are levels held until their response; memory stalls by withholding mem_ack_i.
module memory_port_arbiter #(
  parameter int STARVATION_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  memory_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVATION_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVATION_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          drop;

  logic data_req;
  logic fetch_forced;
  logic fetch_win;

  // Data normally wins; a fetch that has waited out LIMIT data grants is forced through.
  // A flush in the arbitration cycle blocks any fetch grant but never a data grant.
  assign data_req     = bus.data_read_request_i | bus.data_write_request_i;
  assign fetch_forced = bus.instruction_request_i && !bus.flush_bus_i && (starve_cnt == LIMIT_C);
  assign fetch_win    = fetch_forced || (bus.instruction_request_i && !bus.flush_bus_i && !data_req);

  // Single FSM: arbitration, memory command registers and response pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                      <= IDLE;
      starve_cnt                 <= '0;
      drop                       <= 1'b0;
      bus.instruction_response_o <= 1'b0;
      bus.instruction_data_o     <= '0;
      bus.data_response_o        <= 1'b0;
      bus.data_read_data_o       <= '0;
      bus.mem_read_o             <= 1'b0;
      bus.mem_write_o            <= 1'b0;
      bus.mem_addr_o             <= '0;
      bus.mem_write_data_o       <= '0;
      bus.mem_strobe_o           <= '0;
    end else begin
      bus.instruction_response_o <= 1'b0;
      bus.data_response_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_win) begin
            state                <= FETCH;
            starve_cnt           <= '0;
            bus.mem_read_o       <= 1'b1;
            bus.mem_write_o      <= 1'b0;
            bus.mem_addr_o       <= bus.instruction_addr_i;
            bus.mem_write_data_o <= '0;
            bus.mem_strobe_o     <= 4'hF;
          end else if (data_req) begin
            state                <= DATA;
            // read+write together is a store
            bus.mem_read_o       <= !bus.data_write_request_i;
            bus.mem_write_o      <= bus.data_write_request_i;
            bus.mem_addr_o       <= bus.data_addr_i;
            bus.mem_write_data_o <= bus.data_write_request_i ? bus.data_write_data_i : 32'h0;
            bus.mem_strobe_o     <= bus.data_write_request_i ? bus.data_strobe_i : 4'hF;
            if (bus.instruction_request_i && (starve_cnt != LIMIT_C)) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end
        end
        FETCH: begin
          if (bus.flush_bus_i) begin
            drop <= 1'b1;
          end
          if (bus.mem_ack_i) begin
            state          <= IDLE;
            drop           <= 1'b0;
            bus.mem_read_o <= 1'b0;
            // a flush seen at any point of the fetch, ack cycle included, swallows the reply
            if (!drop && !bus.flush_bus_i) begin
              bus.instruction_response_o <= 1'b1;
              bus.instruction_data_o     <= bus.mem_read_data_i;
            end
          end
        end
        DATA: begin
          if (bus.mem_ack_i) begin
            state               <= IDLE;
            bus.mem_read_o      <= 1'b0;
            bus.mem_write_o     <= 1'b0;
            bus.data_response_o <= 1'b1;
            if (!bus.mem_write_o) begin
              bus.data_read_data_o <= bus.mem_read_data_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_memory_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_port_arbiter_if bus ();

  memory_port_arbiter #(.STARVATION_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] last_rdata;
  logic [31:0] last_idata;

  function automatic logic [135:0] outs();
    return {bus.instruction_response_o, bus.instruction_data_o, bus.data_response_o,
            bus.data_read_data_o, bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o,
            bus.mem_write_data_o, bus.mem_strobe_o};
  endfunction

  task automatic idle_inputs();
    bus.instruction_request_i = 1'b0;
    bus.flush_bus_i           = 1'b0;
    bus.instruction_addr_i    = 32'h0;
    bus.data_read_request_i   = 1'b0;
    bus.data_write_request_i  = 1'b0;
    bus.data_addr_i           = 32'h0;
    bus.data_write_data_i     = 32'h0;
    bus.data_strobe_i         = 4'h0;
    bus.mem_ack_i             = 1'b0;
    bus.mem_read_data_i       = 32'h0;
  endtask

  // Wait (bounded) for a memory command to become visible.
  task automatic wait_cmd(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_read_o || bus.mem_write_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Memory responder: capture the command, ack on its lat-th cycle. Returns on the
  // falling edge where the response pulse is visible.
  task automatic serve(input int lat, input logic [31:0] rdat, output bit got,
                       output logic c_rd, output logic c_wr, output logic [31:0] c_addr,
                       output logic [31:0] c_wdat, output logic [3:0] c_strb, output int hi);
    c_rd = 1'b0; c_wr = 1'b0; c_addr = 32'h0; c_wdat = 32'h0; c_strb = 4'h0; hi = 0;
    wait_cmd(got);
    if (!got) return;
    c_rd = bus.mem_read_o; c_wr = bus.mem_write_o; c_addr = bus.mem_addr_o;
    c_wdat = bus.mem_write_data_o; c_strb = bus.mem_strobe_o;
    for (int i = 1; i <= lat; i++) begin
      if (bus.mem_read_o || bus.mem_write_o) hi++;
      if (i == lat) begin
        bus.mem_ack_i = 1'b1;
        bus.mem_read_data_i = rdat;
      end
      @(negedge clk);
    end
    bus.mem_ack_i = 1'b0;
    bus.mem_read_data_i = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 136'h0) $display("FAIL reset_outputs: got %h expected 0", outs());
    else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_ack_i = 1'b1;
    bus.mem_read_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_read_data_i = 32'h0;
    @(negedge clk);
    checks++;
    if (outs() !== 136'h0) $display("FAIL idle_ack_ignored: got %h expected 0", outs());
    else passes++;
    last_rdata = 32'h0;
    last_idata = 32'h0;
  endtask

  task automatic test_fetch_only();
    bit got; logic rd, wr; logic [31:0] a, wd; logic [3:0] st; int hi;
    bus.instruction_request_i = 1'b1;
    bus.instruction_addr_i = 32'h100;
    serve(2, 32'h0000_0013, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({got, rd, wr, a, st} !== {1'b1, 1'b1, 1'b0, 32'h100, 4'hF})
      $display("FAIL fetch_cmd: got %b%b%b %h %h expected 110 00000100 f", got, rd, wr, a, st);
    else passes++;
    checks++;
    if (hi !== 2) $display("FAIL fetch_read_cycles: got %0d expected 2", hi);
    else passes++;
    checks++;
    if ({bus.instruction_response_o, bus.instruction_data_o, bus.data_response_o, bus.mem_read_o}
        !== {1'b1, 32'h13, 1'b0, 1'b0})
      $display("FAIL fetch_resp: got %b %h %b %b expected 1 00000013 0 0", bus.instruction_response_o,
               bus.instruction_data_o, bus.data_response_o, bus.mem_read_o);
    else passes++;
    last_idata = 32'h13;
    bus.instruction_request_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.instruction_response_o, bus.mem_read_o} !== 2'b00)
      $display("FAIL fetch_pulse_end: got %b%b expected 00", bus.instruction_response_o, bus.mem_read_o);
    else passes++;
  endtask

  task automatic test_priority();
    bit got; logic rd, wr; logic [31:0] a, wd; logic [3:0] st; int hi;
    bus.instruction_request_i = 1'b1;
    bus.instruction_addr_i = 32'h200;
    bus.data_read_request_i = 1'b1;
    bus.data_addr_i = 32'h8000;
    serve(1, 32'h1111, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({rd, wr, a, st} !== {1'b1, 1'b0, 32'h8000, 4'hF})
      $display("FAIL prio_first_grant: got %b%b %h %h expected 10 00008000 f", rd, wr, a, st);
    else passes++;
    checks++;
    if ({bus.data_response_o, bus.instruction_response_o, bus.data_read_data_o} !== {2'b10, 32'h1111})
      $display("FAIL prio_load_resp: got %b%b %h expected 10 00001111", bus.data_response_o,
               bus.instruction_response_o, bus.data_read_data_o);
    else passes++;
    last_rdata = 32'h1111;
    bus.data_read_request_i = 1'b0;
    serve(1, 32'h2222, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({rd, a} !== {1'b1, 32'h200}) $display("FAIL prio_second_grant: got %b %h expected 1 00000200", rd, a);
    else passes++;
    checks++;
    if ({bus.instruction_response_o, bus.data_response_o, bus.instruction_data_o} !== {2'b10, 32'h2222})
      $display("FAIL prio_fetch_resp: got %b%b %h expected 10 00002222", bus.instruction_response_o,
               bus.data_response_o, bus.instruction_data_o);
    else passes++;
    last_idata = 32'h2222;
    bus.instruction_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit got; logic rd, wr; logic [31:0] a, wd; logic [3:0] st; int hi;
    int s;
    bit exp_fetch;
    s = 0;
    bus.instruction_request_i = 1'b1;
    bus.instruction_addr_i = 32'h300;
    bus.data_read_request_i = 1'b1;
    bus.data_addr_i = 32'h9000;
    for (int t = 0; t < 10; t++) begin
      exp_fetch = (s == LIMIT);
      s = exp_fetch ? 0 : s + 1;
      serve(1, 32'hA000_0000 + t, got, rd, wr, a, wd, st, hi);
      checks++;
      if (a !== (exp_fetch ? 32'h300 : 32'h9000))
        $display("FAIL starve_grant_%0d: got %h expected %h", t, a, exp_fetch ? 32'h300 : 32'h9000);
      else passes++;
      checks++;
      if ({bus.instruction_response_o, bus.data_response_o} !== (exp_fetch ? 2'b10 : 2'b01))
        $display("FAIL starve_resp_%0d: got %b%b expected %b", t, bus.instruction_response_o,
                 bus.data_response_o, exp_fetch ? 2'b10 : 2'b01);
      else passes++;
      if (exp_fetch) last_idata = 32'hA000_0000 + t;
      else last_rdata = 32'hA000_0000 + t;
    end
    bus.instruction_request_i = 1'b0;
    bus.data_read_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit got; logic rd, wr; logic [31:0] a, wd; logic [3:0] st; int hi;
    // flush while the fetch waits for memory
    bus.instruction_request_i = 1'b1;
    bus.instruction_addr_i = 32'h400;
    wait_cmd(got);
    checks++;
    if ({got, bus.mem_addr_o} !== {1'b1, 32'h400})
      $display("FAIL flush_first_cmd: got %b %h expected 1 00000400", got, bus.mem_addr_o);
    else passes++;
    bus.flush_bus_i = 1'b1;
    bus.instruction_addr_i = 32'h500;
    @(negedge clk);
    bus.flush_bus_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    bus.mem_read_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_read_data_i = 32'h0;
    checks++;
    if ({bus.instruction_response_o, bus.instruction_data_o, bus.mem_read_o} !== {1'b0, last_idata, 1'b0})
      $display("FAIL flush_dropped: got %b %h %b expected 0 %h 0", bus.instruction_response_o,
               bus.instruction_data_o, bus.mem_read_o, last_idata);
    else passes++;
    serve(1, 32'h0000_600D, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({bus.instruction_response_o, bus.instruction_data_o, a} !== {1'b1, 32'h600D, 32'h500})
      $display("FAIL flush_refetch: got %b %h %h expected 1 0000600d 00000500",
               bus.instruction_response_o, bus.instruction_data_o, a);
    else passes++;
    last_idata = 32'h600D;
    // flush coinciding with the ack
    bus.instruction_addr_i = 32'h700;
    wait_cmd(got);
    bus.flush_bus_i = 1'b1;
    bus.mem_ack_i = 1'b1;
    bus.mem_read_data_i = 32'h1234_5678;
    bus.instruction_addr_i = 32'h704;
    @(negedge clk);
    bus.flush_bus_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    checks++;
    if ({bus.instruction_response_o, bus.instruction_data_o} !== {1'b0, last_idata})
      $display("FAIL flush_at_ack: got %b %h expected 0 %h", bus.instruction_response_o,
               bus.instruction_data_o, last_idata);
    else passes++;
    serve(2, 32'h0000_0704, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({bus.instruction_response_o, a} !== {1'b1, 32'h704})
      $display("FAIL flush_at_ack_refetch: got %b %h expected 1 00000704", bus.instruction_response_o, a);
    else passes++;
    last_idata = 32'h704;
    bus.instruction_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    bit got; logic rd, wr; logic [31:0] a, wd; logic [3:0] st; int hi;
    bus.data_write_request_i = 1'b1;
    bus.data_addr_i = 32'h40;
    bus.data_write_data_i = 32'hCAFE_F00D;
    bus.data_strobe_i = 4'b0011;
    serve(1, 32'h5555_5555, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({rd, wr, a, wd, st} !== {1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'b0011})
      $display("FAIL store_cmd: got %b%b %h %h %h expected 01 00000040 cafef00d 3", rd, wr, a, wd, st);
    else passes++;
    checks++;
    if ({bus.data_response_o, bus.data_read_data_o} !== {1'b1, last_rdata})
      $display("FAIL store_resp: got %b %h expected 1 %h", bus.data_response_o, bus.data_read_data_o, last_rdata);
    else passes++;
    // read and write together behave as a store
    bus.data_read_request_i = 1'b1;
    bus.data_addr_i = 32'h44;
    bus.data_write_data_i = 32'h1122_3344;
    bus.data_strobe_i = 4'b1100;
    serve(2, 32'h7777_7777, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({rd, wr, a, wd, st, bus.data_read_data_o} !== {1'b0, 1'b1, 32'h44, 32'h1122_3344, 4'b1100, last_rdata})
      $display("FAIL rdwr_as_store: got %b%b %h %h %h %h", rd, wr, a, wd, st, bus.data_read_data_o);
    else passes++;
    bus.data_read_request_i = 1'b0;
    bus.data_write_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_data();
    bit got; logic rd, wr; logic [31:0] a, wd; logic [3:0] st; int hi;
    bus.data_read_request_i = 1'b1;
    bus.data_addr_i = 32'h7000;
    wait_cmd(got);
    checks++;
    if ({got, bus.mem_read_o, bus.mem_addr_o} !== {2'b11, 32'h7000})
      $display("FAIL rst_mid_cmd: got %b%b %h expected 11 00007000", got, bus.mem_read_o, bus.mem_addr_o);
    else passes++;
    rst_n = 1'b0;
    bus.data_read_request_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 136'h0) $display("FAIL rst_mid_outputs: got %h expected 0", outs());
    else passes++;
    rst_n = 1'b1;
    bus.mem_ack_i = 1'b1;
    bus.mem_read_data_i = 32'h0BAD;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_read_data_i = 32'h0;
    @(negedge clk);
    checks++;
    if (outs() !== 136'h0) $display("FAIL rst_late_ack: got %h expected 0", outs());
    else passes++;
    bus.data_read_request_i = 1'b1;
    bus.data_addr_i = 32'h7004;
    serve(2, 32'hABCD, got, rd, wr, a, wd, st, hi);
    checks++;
    if ({a, bus.data_response_o, bus.data_read_data_o} !== {32'h7004, 1'b1, 32'hABCD})
      $display("FAIL rst_recover: got %h %b %h expected 00007004 1 0000abcd", a, bus.data_response_o,
               bus.data_read_data_o);
    else passes++;
    bus.data_read_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random(input int ncycles);
    // transaction-level model of the port
    bit busy, is_data, is_wr, drop, fetch_forced;
    int starve, lat, cnt, k;
    logic e_rd, e_wr, e_iresp, e_dresp;
    logic [31:0] e_addr, e_wdat, e_idata, e_rdata;
    logic [3:0] e_strb;
    logic ireq, flush, drd, dwr, ack;
    logic [31:0] iaddr, daddr, dwd, ackd;
    logic [3:0] dstrb;
    logic [70:0] exp_cmd, got_cmd;
    logic [65:0] exp_rsp, got_rsp;

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy = 0; is_data = 0; is_wr = 0; drop = 0; starve = 0; lat = 1; cnt = 0;
    e_rd = 0; e_wr = 0; e_iresp = 0; e_dresp = 0;
    e_addr = 0; e_wdat = 0; e_idata = 0; e_rdata = 0; e_strb = 0;
    ireq = 0; flush = 0; drd = 0; dwr = 0; iaddr = 0; daddr = 0; dwd = 0; dstrb = 0;

    for (int c = 0; c < ncycles; c++) begin
      // requesters react to the responses the model says were just delivered
      if (e_iresp) begin
        ireq = 1'($urandom_range(0, 1));
        iaddr = $urandom;
      end else if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1;
        iaddr = $urandom;
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush && ireq) iaddr = $urandom;
      if (e_dresp) begin
        drd = 1'b0;
        dwr = 1'b0;
      end
      if (!(drd || dwr) && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        drd = (k != 1);
        dwr = (k != 0);
        daddr = $urandom;
        dwd = $urandom;
        dstrb = 4'($urandom);
      end
      // memory: ack after a random latency; occasional stray ack while idle
      if (busy) begin
        cnt++;
        ack = (cnt == lat);
      end else begin
        ack = ($urandom_range(0, 15) == 0);
      end
      ackd = $urandom;

      bus.instruction_request_i = ireq;
      bus.instruction_addr_i    = iaddr;
      bus.flush_bus_i           = flush;
      bus.data_read_request_i   = drd;
      bus.data_write_request_i  = dwr;
      bus.data_addr_i           = daddr;
      bus.data_write_data_i     = dwd;
      bus.data_strobe_i         = dstrb;
      bus.mem_ack_i             = ack;
      bus.mem_read_data_i       = ackd;

      // what the coming clock edge must produce
      e_iresp = 1'b0;
      e_dresp = 1'b0;
      if (busy) begin
        if (!is_data && flush) drop = 1'b1;
        if (ack) begin
          busy = 1'b0;
          e_rd = 1'b0;
          e_wr = 1'b0;
          if (!is_data) begin
            if (!drop) begin
              e_iresp = 1'b1;
              e_idata = ackd;
            end
            drop = 1'b0;
          end else begin
            e_dresp = 1'b1;
            if (!is_wr) e_rdata = ackd;
          end
        end
      end else begin
        fetch_forced = ireq && !flush && (starve == LIMIT);
        if (fetch_forced || (ireq && !flush && !(drd || dwr))) begin
          busy = 1'b1; is_data = 1'b0; starve = 0;
          e_rd = 1'b1; e_wr = 1'b0; e_addr = iaddr; e_wdat = 32'h0; e_strb = 4'hF;
          lat = $urandom_range(1, 3); cnt = 0;
        end else if (drd || dwr) begin
          busy = 1'b1; is_data = 1'b1; is_wr = dwr;
          e_rd = !dwr; e_wr = dwr; e_addr = daddr;
          e_wdat = dwr ? dwd : 32'h0;
          e_strb = dwr ? dstrb : 4'hF;
          if (ireq && starve < LIMIT) starve++;
          lat = $urandom_range(1, 3); cnt = 0;
        end
      end

      @(negedge clk);
      exp_cmd = {e_rd, e_wr, e_addr, e_wdat, e_strb};
      got_cmd = {bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_write_data_o, bus.mem_strobe_o};
      checks++;
      if (got_cmd !== exp_cmd) $display("FAIL rand_cmd cycle %0d: got %h expected %h", c, got_cmd, exp_cmd);
      else passes++;
      exp_rsp = {e_iresp, e_idata, e_dresp, e_rdata};
      got_rsp = {bus.instruction_response_o, bus.instruction_data_o, bus.data_response_o, bus.data_read_data_o};
      checks++;
      if (got_rsp !== exp_rsp) $display("FAIL rand_rsp cycle %0d: got %h expected %h", c, got_rsp, exp_rsp);
      else passes++;
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid_data();
    test_random(3000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
